// File: rtl/npc_ctrl.sv
// ============================================================================
// Module      : npc_ctrl
// Description : Next-PC controller. Arbitrates redirects against sequential
//               advance and sequences I-cache fetch requests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module npc_ctrl #(
  parameter logic [31:0] RESET_PC         = 32'h1c000000,
  parameter int          PRED_KILL_CYCLES = 1,
  parameter int          CNT_W            = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             excp_valid_i,
  input  logic [31:0]      excp_target_i,
  input  logic             br_valid_i,
  input  logic [31:0]      br_target_i,
  input  logic             pred_valid_i,
  input  logic [31:0]      pred_target_i,
  input  logic             stall_i,
  input  logic             idle_i,
  input  logic             wake_i,
  input  logic             fetch_ready_i,
  output logic             fetch_valid_o,
  output logic [31:0]      pc_o,
  output logic             flush_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  localparam logic [1:0] c_KILL_INIT = 2'(PRED_KILL_CYCLES);

  typedef enum logic [1:0] {
    S_BOOT = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_hold;
  logic [1:0]       r_kill;
  logic [CNT_W-1:0] r_cnt;
  logic             w_hard;
  logic             w_redirect;
  logic             w_to_halt;
  logic             w_adv;
  logic [31:0]      w_target;
  logic [31:0]      w_pc_nxt;

  always_comb begin
    w_hard     = excp_valid_i | br_valid_i;
    w_redirect = w_hard | (pred_valid_i & (r_kill == 2'd0));

    w_target = pred_target_i;
    if (excp_valid_i)    w_target = excp_target_i;
    else if (br_valid_i) w_target = br_target_i;

    // A request left hanging last cycle stays up even if stall_i rises.
    fetch_valid_o = (r_state == S_RUN) & (~stall_i | r_hold);

    w_state_nxt = r_state;
    w_to_halt   = 1'b0;
    case (r_state)
      S_BOOT: w_state_nxt = S_RUN;
      S_RUN: begin
        if (idle_i & ~excp_valid_i & ~wake_i) begin
          w_state_nxt = S_HALT;
          w_to_halt   = 1'b1;
        end
      end
      S_HALT: begin
        if (wake_i | excp_valid_i) w_state_nxt = S_RUN;
      end
      default: w_state_nxt = S_BOOT;
    endcase

    w_adv    = ~w_redirect & fetch_valid_o & fetch_ready_i & ~w_to_halt;
    w_pc_nxt = pc_o;
    if (w_redirect)  w_pc_nxt = {w_target[31:2], 2'b00};
    else if (w_adv)  w_pc_nxt = {pc_o[31:3] + 29'd1, 3'b000};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_BOOT;
      pc_o    <= RESET_PC;
      flush_o <= 1'b0;
      r_hold  <= 1'b0;
      r_kill  <= 2'd0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      pc_o    <= w_pc_nxt;
      flush_o <= w_hard;
      r_hold  <= fetch_valid_o & ~fetch_ready_i & ~w_redirect;
      if (w_hard)              r_kill <= c_KILL_INIT;
      else if (r_kill != 2'd0) r_kill <= r_kill - 2'd1;
      if (w_redirect && !(&r_cnt)) r_cnt <= r_cnt + 1'b1;
    end
  end

  assign halted_o       = (r_state == S_HALT);
  assign redirect_cnt_o = r_cnt;

endmodule

`default_nettype wire
